// File: rtl/kvs_axis_latency_probe.sv
`default_nettype none
// ============================================================================
// Module      : kvs_axis_latency_probe
// Description : AXI-Stream request/response probe. Passes both streams through
//               combinationally, timestamps each request at its last beat,
//               matches responses in order and reports per-request latency,
//               packet counts and min/max/sum latency statistics. Limits the
//               number of outstanding requests and supports a drain request.
// Revision    : 1.0 - initial release
// ============================================================================
module kvs_axis_latency_probe #(
    parameter int DATA_WIDTH      = 64,
    parameter int USER_WIDTH      = 64,
    parameter int TS_WIDTH        = 48,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = 32,
    parameter int SUM_WIDTH       = 64
) (
    input  logic                              clk_390,
    input  logic                              clk_390_rst_n,
    // request stream from the network
    input  logic [DATA_WIDTH-1:0]             from_net_tdata,
    input  logic [DATA_WIDTH/8-1:0]           from_net_tkeep,
    input  logic [USER_WIDTH-1:0]             from_net_tuser,
    input  logic                              from_net_tvalid,
    input  logic                              from_net_tlast,
    output logic                              from_net_tready,
    // request stream to the KVS
    output logic [DATA_WIDTH-1:0]             to_kvs_tdata,
    output logic [DATA_WIDTH/8-1:0]           to_kvs_tkeep,
    output logic [USER_WIDTH-1:0]             to_kvs_tuser,
    output logic                              to_kvs_tvalid,
    output logic                              to_kvs_tlast,
    input  logic                              to_kvs_tready,
    // response stream from the KVS
    input  logic [DATA_WIDTH-1:0]             from_kvs_tdata,
    input  logic [DATA_WIDTH/8-1:0]           from_kvs_tkeep,
    input  logic [USER_WIDTH-1:0]             from_kvs_tuser,
    input  logic                              from_kvs_tvalid,
    input  logic                              from_kvs_tlast,
    output logic                              from_kvs_tready,
    // response stream to the network
    output logic [DATA_WIDTH-1:0]             to_net_tdata,
    output logic [DATA_WIDTH/8-1:0]           to_net_tkeep,
    output logic [USER_WIDTH-1:0]             to_net_tuser,
    output logic                              to_net_tvalid,
    output logic                              to_net_tlast,
    input  logic                              to_net_tready,
    // control and statistics
    input  logic                              drain_i,
    input  logic                              stat_clr_i,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              lat_valid_o,
    output logic [TS_WIDTH-1:0]               lat_value_o,
    output logic [CNT_WIDTH-1:0]              pkts_in_o,
    output logic [CNT_WIDTH-1:0]              pkts_out_o,
    output logic [TS_WIDTH-1:0]               lat_min_o,
    output logic [TS_WIDTH-1:0]               lat_max_o,
    output logic [SUM_WIDTH-1:0]              lat_sum_o,
    output logic                              underflow_o
);

    localparam int                c_addr_w = $clog2(MAX_OUTSTANDING);
    localparam logic [c_addr_w:0] c_full   = (c_addr_w + 1)'(MAX_OUTSTANDING);

    // Registered state
    logic [TS_WIDTH-1:0]   r_ts;
    logic [TS_WIDTH-1:0]   r_ts_mem [MAX_OUTSTANDING];
    logic [c_addr_w-1:0]   r_wr_ptr;
    logic [c_addr_w-1:0]   r_rd_ptr;
    logic [c_addr_w:0]     r_count;
    logic                  r_in_mid;
    logic                  r_drain_pend;
    logic                  r_lat_valid;
    logic [TS_WIDTH-1:0]   r_lat_value;
    logic [CNT_WIDTH-1:0]  r_pkts_in;
    logic [CNT_WIDTH-1:0]  r_pkts_out;
    logic [TS_WIDTH-1:0]   r_lat_min;
    logic [TS_WIDTH-1:0]   r_lat_max;
    logic [SUM_WIDTH-1:0]  r_lat_sum;
    logic                  r_underflow;

    // Combinational handshake decode
    logic                  w_gate;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_push;
    logic                  w_pop_hs;
    logic                  w_pop_ok;
    logic                  w_underflow;
    logic [TS_WIDTH-1:0]   w_lat;

    // The gate only closes between packets, so a started packet always completes.
    assign w_gate = ~r_in_mid & ((r_count == c_full) | r_drain_pend);

    assign to_kvs_tdata    = from_net_tdata;
    assign to_kvs_tkeep    = from_net_tkeep;
    assign to_kvs_tuser    = from_net_tuser;
    assign to_kvs_tlast    = from_net_tlast;
    assign to_kvs_tvalid   = from_net_tvalid & ~w_gate;
    assign from_net_tready = to_kvs_tready & ~w_gate;

    assign to_net_tdata    = from_kvs_tdata;
    assign to_net_tkeep    = from_kvs_tkeep;
    assign to_net_tuser    = from_kvs_tuser;
    assign to_net_tlast    = from_kvs_tlast;
    assign to_net_tvalid   = from_kvs_tvalid;
    assign from_kvs_tready = to_net_tready;

    assign w_in_hs     = to_kvs_tvalid & to_kvs_tready;
    assign w_out_hs    = to_net_tvalid & to_net_tready;
    assign w_push      = w_in_hs & to_kvs_tlast;
    assign w_pop_hs    = w_out_hs & to_net_tlast;
    assign w_pop_ok    = w_pop_hs & (r_count != '0);
    assign w_underflow = w_pop_hs & (r_count == '0);

    // Modular subtraction keeps the latency correct across timestamp wrap.
    assign w_lat = r_ts - r_ts_mem[r_rd_ptr];

    assign outstanding_o = r_count;
    assign lat_valid_o   = r_lat_valid;
    assign lat_value_o   = r_lat_value;
    assign pkts_in_o     = r_pkts_in;
    assign pkts_out_o    = r_pkts_out;
    assign lat_min_o     = r_lat_min;
    assign lat_max_o     = r_lat_max;
    assign lat_sum_o     = r_lat_sum;
    assign underflow_o   = r_underflow;

    // Free-running timestamp.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Timestamp storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk_390) begin
        if (w_push) begin
            r_ts_mem[r_wr_ptr] <= r_ts;
        end
    end

    // FIFO pointers and occupancy; a push and a valid pop together leave it unchanged.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Packet-boundary tracking and drain request; a new drain request beats the clear.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            r_in_mid     <= 1'b0;
            r_drain_pend <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_in_mid <= ~to_kvs_tlast;
            end
            if (drain_i) begin
                r_drain_pend <= 1'b1;
            end else if ((r_count == '0) && !r_in_mid) begin
                r_drain_pend <= 1'b0;
            end
        end
    end

    // Per-request latency report, one cycle after the matching response.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            r_lat_valid <= 1'b0;
            r_lat_value <= '0;
        end else begin
            r_lat_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_lat_value <= w_lat;
            end
        end
    end

    // Running statistics; a clear overrides any update in the same cycle.
    always_ff @(posedge clk_390 or negedge clk_390_rst_n) begin
        if (!clk_390_rst_n) begin
            r_pkts_in   <= '0;
            r_pkts_out  <= '0;
            r_lat_min   <= '1;
            r_lat_max   <= '0;
            r_lat_sum   <= '0;
            r_underflow <= 1'b0;
        end else if (stat_clr_i) begin
            r_pkts_in   <= '0;
            r_pkts_out  <= '0;
            r_lat_min   <= '1;
            r_lat_max   <= '0;
            r_lat_sum   <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_pkts_in <= r_pkts_in + 1'b1;
            end
            if (w_pop_hs) begin
                r_pkts_out <= r_pkts_out + 1'b1;
            end
            if (w_pop_ok) begin
                if (w_lat < r_lat_min) begin
                    r_lat_min <= w_lat;
                end
                if (w_lat > r_lat_max) begin
                    r_lat_max <= w_lat;
                end
                r_lat_sum <= r_lat_sum + SUM_WIDTH'(w_lat);
            end
            if (w_underflow) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kvs_axis_latency_probe.sv
`default_nettype none
// ============================================================================
// Module      : tb_kvs_axis_latency_probe
// Description : Self-checking bench for kvs_axis_latency_probe. A queue-based
//               reference model tracks outstanding timestamps and statistics
//               and is compared against the DUT every cycle; directed
//               scenarios pin the model with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kvs_axis_latency_probe;

    localparam int DW   = 64;
    localparam int UW   = 64;
    localparam int TSW  = 8;
    localparam int MAXO = 4;
    localparam int CW   = 32;
    localparam int SW   = 64;

    logic            clk_390 = 1'b0;
    logic            clk_390_rst_n;
    logic [DW-1:0]   from_net_tdata,  to_kvs_tdata,  from_kvs_tdata,  to_net_tdata;
    logic [DW/8-1:0] from_net_tkeep,  to_kvs_tkeep,  from_kvs_tkeep,  to_net_tkeep;
    logic [UW-1:0]   from_net_tuser,  to_kvs_tuser,  from_kvs_tuser,  to_net_tuser;
    logic            from_net_tvalid, to_kvs_tvalid, from_kvs_tvalid, to_net_tvalid;
    logic            from_net_tlast,  to_kvs_tlast,  from_kvs_tlast,  to_net_tlast;
    logic            from_net_tready, to_kvs_tready, from_kvs_tready, to_net_tready;
    logic            drain_i, stat_clr_i;
    logic [$clog2(MAXO):0] outstanding_o;
    logic            lat_valid_o;
    logic [TSW-1:0]  lat_value_o, lat_min_o, lat_max_o;
    logic [CW-1:0]   pkts_in_o, pkts_out_o;
    logic [SW-1:0]   lat_sum_o;
    logic            underflow_o;

    kvs_axis_latency_probe #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .TS_WIDTH(TSW),
        .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW), .SUM_WIDTH(SW)
    ) dut (
        .clk_390(clk_390), .clk_390_rst_n(clk_390_rst_n),
        .from_net_tdata(from_net_tdata), .from_net_tkeep(from_net_tkeep),
        .from_net_tuser(from_net_tuser), .from_net_tvalid(from_net_tvalid),
        .from_net_tlast(from_net_tlast), .from_net_tready(from_net_tready),
        .to_kvs_tdata(to_kvs_tdata), .to_kvs_tkeep(to_kvs_tkeep),
        .to_kvs_tuser(to_kvs_tuser), .to_kvs_tvalid(to_kvs_tvalid),
        .to_kvs_tlast(to_kvs_tlast), .to_kvs_tready(to_kvs_tready),
        .from_kvs_tdata(from_kvs_tdata), .from_kvs_tkeep(from_kvs_tkeep),
        .from_kvs_tuser(from_kvs_tuser), .from_kvs_tvalid(from_kvs_tvalid),
        .from_kvs_tlast(from_kvs_tlast), .from_kvs_tready(from_kvs_tready),
        .to_net_tdata(to_net_tdata), .to_net_tkeep(to_net_tkeep),
        .to_net_tuser(to_net_tuser), .to_net_tvalid(to_net_tvalid),
        .to_net_tlast(to_net_tlast), .to_net_tready(to_net_tready),
        .drain_i(drain_i), .stat_clr_i(stat_clr_i),
        .outstanding_o(outstanding_o), .lat_valid_o(lat_valid_o),
        .lat_value_o(lat_value_o), .pkts_in_o(pkts_in_o), .pkts_out_o(pkts_out_o),
        .lat_min_o(lat_min_o), .lat_max_o(lat_max_o), .lat_sum_o(lat_sum_o),
        .underflow_o(underflow_o)
    );

    always #5 clk_390 = ~clk_390;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Bench's own view of the free-running timestamp at the next clock edge.
    logic [TSW-1:0] ts_ref;
    always @(posedge clk_390) begin
        if (!clk_390_rst_n) ts_ref <= '0;
        else                ts_ref <= ts_ref + 1'b1;
    end

    // ------------------------------------------------------------------
    // Reference model and per-cycle comparison
    // ------------------------------------------------------------------
    logic [TSW-1:0] m_q[$];
    logic [TSW-1:0] m_ts, m_lat_value, m_min, m_max;
    logic [CW-1:0]  m_pin, m_pout;
    logic [SW-1:0]  m_sum;
    bit             m_mid, m_drain, m_lat_valid, m_uf;

    initial begin : p_compare
        bit gate, in_hs, push, pop, clr_cond;
        logic [TSW-1:0] lat;
        forever begin
            @(negedge clk_390);
            if (!clk_390_rst_n) begin
                m_q.delete();
                m_ts = '0; m_lat_value = '0; m_min = '1; m_max = '0;
                m_pin = '0; m_pout = '0; m_sum = '0;
                m_mid = 0; m_drain = 0; m_lat_valid = 0; m_uf = 0;
            end else begin
                gate = !m_mid && ((m_q.size() == MAXO) || m_drain);
                chk("from_net_tready", from_net_tready, to_kvs_tready && !gate);
                chk("to_kvs_tvalid", to_kvs_tvalid, from_net_tvalid && !gate);
                chk("to_kvs_tdata", to_kvs_tdata, from_net_tdata);
                chk("to_kvs_side", {to_kvs_tkeep, to_kvs_tlast}, {from_net_tkeep, from_net_tlast});
                chk("to_kvs_tuser", to_kvs_tuser, from_net_tuser);
                chk("to_net_tdata", to_net_tdata, from_kvs_tdata);
                chk("to_net_ctrl", {to_net_tkeep, to_net_tvalid, to_net_tlast, from_kvs_tready},
                                   {from_kvs_tkeep, from_kvs_tvalid, from_kvs_tlast, to_net_tready});
                chk("to_net_tuser", to_net_tuser, from_kvs_tuser);
                chk("outstanding", outstanding_o, m_q.size());
                chk("lat_valid", lat_valid_o, m_lat_valid);
                if (m_lat_valid) chk("lat_value", lat_value_o, m_lat_value);
                chk("pkts_in", pkts_in_o, m_pin);
                chk("pkts_out", pkts_out_o, m_pout);
                chk("lat_min", lat_min_o, m_min);
                chk("lat_max", lat_max_o, m_max);
                chk("lat_sum", lat_sum_o, m_sum);
                chk("underflow", underflow_o, m_uf);

                // Advance the model across the coming clock edge.
                in_hs    = from_net_tvalid && !gate && to_kvs_tready;
                push     = in_hs && from_net_tlast;
                pop      = from_kvs_tvalid && to_net_tready && from_kvs_tlast;
                clr_cond = (m_q.size() == 0) && !m_mid;
                m_lat_valid = 0;
                if (pop) begin
                    m_pout++;
                    if (m_q.size() > 0) begin
                        lat = m_ts - m_q.pop_front();
                        m_lat_valid = 1;
                        m_lat_value = lat;
                        if (lat < m_min) m_min = lat;
                        if (lat > m_max) m_max = lat;
                        m_sum = m_sum + SW'(lat);
                    end else begin
                        m_uf = 1;
                    end
                end
                if (push) begin
                    m_q.push_back(m_ts);
                    m_pin++;
                end
                if (drain_i)       m_drain = 1;
                else if (clr_cond) m_drain = 0;
                if (in_hs) m_mid = !from_net_tlast;
                if (stat_clr_i) begin
                    m_pin = '0; m_pout = '0; m_min = '1; m_max = '0; m_sum = '0; m_uf = 0;
                end
                m_ts = m_ts + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_390);
        #1;
    endtask

    task automatic idle_inputs();
        from_net_tvalid = 0; from_net_tlast = 0;
        from_kvs_tvalid = 0; from_kvs_tlast = 0;
        to_kvs_tready = 1; to_net_tready = 1;
        drain_i = 0; stat_clr_i = 0;
    endtask

    task automatic req_beat(input bit last);
        from_net_tvalid = 1; from_net_tlast = last;
        from_net_tdata = {$urandom, $urandom};
        from_net_tkeep = 8'($urandom);
        from_net_tuser = {$urandom, $urandom};
    endtask

    task automatic rsp_beat(input bit last);
        from_kvs_tvalid = 1; from_kvs_tlast = last;
        from_kvs_tdata = {$urandom, $urandom};
        from_kvs_tkeep = 8'($urandom);
        from_kvs_tuser = {$urandom, $urandom};
    endtask

    task automatic wait_ts(input logic [TSW-1:0] v);
        for (int i = 0; i < 300 && ts_ref != v; i++) tick();
        chk("wait_ts", ts_ref, v);
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) != 0) req_beat($urandom_range(0, 2) == 0);
            else from_net_tvalid = 0;
            to_kvs_tready = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) rsp_beat($urandom_range(0, 1) == 1);
            else from_kvs_tvalid = 0;
            to_net_tready = ($urandom_range(0, 3) != 0);
            drain_i    = ($urandom_range(0, 99) == 0);
            stat_clr_i = ($urandom_range(0, 149) == 0);
            tick();
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios followed by randomized traffic
    // ------------------------------------------------------------------
    initial begin
        clk_390_rst_n = 0;
        from_net_tdata = '0; from_net_tkeep = '0; from_net_tuser = '0;
        from_kvs_tdata = '0; from_kvs_tkeep = '0; from_kvs_tuser = '0;
        idle_inputs();
        repeat (3) tick();
        clk_390_rst_n = 1;

        // Reset state
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_lat_min", lat_min_o, 8'hFF);
        chk("rst_counts", {pkts_in_o, pkts_out_o}, 0);
        chk("rst_stats", {lat_max_o, lat_sum_o[31:0], underflow_o, lat_valid_o}, 0);

        // Single request: 3-beat request, 2-beat response 20 cycles later
        req_beat(0); tick(); req_beat(0); tick(); req_beat(1); tick();
        from_net_tvalid = 0;
        chk("t1_outstanding", outstanding_o, 1);
        repeat (18) tick();
        rsp_beat(0); tick(); rsp_beat(1); tick();
        from_kvs_tvalid = 0;
        chk("t1_lat_valid", lat_valid_o, 1);
        chk("t1_lat_value", lat_value_o, 20);
        chk("t1_pkts", {pkts_in_o, pkts_out_o}, {32'd1, 32'd1});
        chk("t1_min_max", {lat_min_o, lat_max_o}, {8'd20, 8'd20});
        chk("t1_sum", lat_sum_o, 20);
        tick();
        chk("t1_strobe_once", lat_valid_o, 0);

        // Outstanding limit
        req_beat(1);
        repeat (4) tick();
        chk("t2_full", outstanding_o, 4);
        chk("t2_gated", from_net_tready, 0);
        repeat (2) tick();
        chk("t2_hold", outstanding_o, 4);
        rsp_beat(1); tick(); from_kvs_tvalid = 0;
        chk("t2_after_pop", outstanding_o, 3);
        chk("t2_reopen", from_net_tready, 1);
        tick();
        chk("t2_refill", outstanding_o, 4);
        chk("t2_regated", from_net_tready, 0);
        from_net_tvalid = 0;
        rsp_beat(1); repeat (4) tick(); from_kvs_tvalid = 0;
        chk("t2_empty", outstanding_o, 0);

        // Drain during a 4-beat request
        req_beat(0); tick();
        req_beat(0); drain_i = 1; tick(); drain_i = 0;
        req_beat(0); tick(); req_beat(1); tick();
        chk("t3_completed", outstanding_o, 1);
        req_beat(1); tick();
        chk("t3_stalled", from_net_tready, 0);
        tick();
        chk("t3_still_stalled", outstanding_o, 1);
        rsp_beat(1); tick(); from_kvs_tvalid = 0;
        chk("t3_zero", outstanding_o, 0);
        chk("t3_pend", from_net_tready, 0);
        tick();
        chk("t3_released", from_net_tready, 1);
        tick(); from_net_tvalid = 0;
        chk("t3_next_pkt", outstanding_o, 1);
        rsp_beat(1); tick(); from_kvs_tvalid = 0;

        // Underflow
        stat_clr_i = 1; tick(); stat_clr_i = 0;
        chk("t4_cleared", pkts_out_o, 0);
        rsp_beat(1); tick(); from_kvs_tvalid = 0;
        chk("t4_underflow", underflow_o, 1);
        chk("t4_pkts_out", pkts_out_o, 1);
        chk("t4_no_lat", lat_valid_o, 0);
        chk("t4_min", lat_min_o, 8'hFF);
        tick();
        chk("t4_sticky", underflow_o, 1);
        stat_clr_i = 1; tick(); stat_clr_i = 0;
        chk("t4_clr", underflow_o, 0);

        // Timestamp wrap
        wait_ts(8'd250);
        req_beat(1); tick(); from_net_tvalid = 0;
        wait_ts(8'd4);
        rsp_beat(1); tick(); from_kvs_tvalid = 0;
        chk("t5_valid", lat_valid_o, 1);
        chk("t5_wrap_lat", lat_value_o, 10);

        // Simultaneous push and pop with two outstanding
        wait_ts(8'd100);
        req_beat(1); tick(); tick(); from_net_tvalid = 0;
        chk("t6_two", outstanding_o, 2);
        wait_ts(8'd130);
        req_beat(1); rsp_beat(1); tick();
        from_net_tvalid = 0; from_kvs_tvalid = 0;
        chk("t6_same", outstanding_o, 2);
        chk("t6_valid", lat_valid_o, 1);
        chk("t6_oldest", lat_value_o, 30);
        rsp_beat(1); repeat (2) tick(); from_kvs_tvalid = 0;
        chk("t6_empty", outstanding_o, 0);

        // Randomized traffic
        random_cycles(4000);

        // Reset in the middle of a packet
        req_beat(0); tick();
        clk_390_rst_n = 0;
        to_kvs_tready = 0;
        #1;
        chk("rst_mid_tready_lo", from_net_tready, 0);
        to_kvs_tready = 1;
        #1;
        chk("rst_mid_tready_hi", from_net_tready, 1);
        chk("rst_mid_outstanding", outstanding_o, 0);
        chk("rst_mid_min", lat_min_o, 8'hFF);
        chk("rst_mid_pkts", pkts_in_o, 0);
        from_net_tvalid = 0;
        tick(); tick();
        clk_390_rst_n = 1;
        random_cycles(300);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kvs_axis_latency_probe.md
# kvs_axis_latency_probe

Parametrised, synthesizable AXI-Stream request/response probe placed between the network-side streams and the KVS datapath. It passes request and response streams through unchanged and timestamps every request packet at its last beat. It matches each response packet in order, then reports per-request latency and running statistics. It also enforces an outstanding-request limit and an on-demand drain, so hardware runs report the same TX/RX counts and latencies the KVS simulation flow reports.

## Interface
- DATA_WIDTH, 64, tdata width; tkeep is DATA_WIDTH/8.
- USER_WIDTH, 64, tuser width.
- TS_WIDTH, 48, free-running timestamp and latency width.
- MAX_OUTSTANDING, 16, timestamp FIFO depth; power of two, at least 2.
- CNT_WIDTH, 32, packet counter width.
- SUM_WIDTH, 64, latency accumulator width.

- clk_390  in  1  stream clock.
- clk_390_rst_n  in  1  asynchronous, active-low reset.
- from_net_t{data,keep,user,valid,last}  in  request stream from the network.
- from_net_tready  out  1  ready back to the network.
- to_kvs_t{data,keep,user,valid,last}  out  request stream to the KVS.
- to_kvs_tready  in  1.
- from_kvs_t{data,keep,user,valid,last}  in  response stream from the KVS.
- from_kvs_tready  out  1.
- to_net_t{data,keep,user,valid,last}  out  response stream to the network.
- to_net_tready  in  1.
- drain_i  in  1  pulse that requests a drain.
- stat_clr_i  in  1  synchronous clear of all statistics.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  number of timestamps held.
- lat_valid_o  out  1  one-cycle strobe.
- lat_value_o  out  TS_WIDTH  latency of the matched request.
- pkts_in_o, pkts_out_o  out  CNT_WIDTH  completed request and response packets.
- lat_min_o, lat_max_o  out  TS_WIDTH.
- lat_sum_o  out  SUM_WIDTH.
- underflow_o  out  1  sticky: a response arrived with no outstanding request.

## Operation
- **Pass-through.**
  - All data, keep, user and last signals are combinational wires through the block.
  - to_kvs_tvalid = from_net_tvalid & ~gate.
  - from_net_tready = to_kvs_tready & ~gate.
  - The response path is never gated: to_net_* = from_kvs_*, from_kvs_tready = to_net_tready.
- **Handshake definitions.**
  - in_hs = to_kvs_tvalid & to_kvs_tready.
  - out_hs = to_net_tvalid & to_net_tready.
- **in_mid.** Set on in_hs with tlast=0; cleared on in_hs with tlast=1.
- **gate.** gate = ~in_mid & (outstanding == MAX_OUTSTANDING | drain_pend). A packet that has started is never stalled by the probe.
- **Timestamp.** ts is a free-running TS_WIDTH counter, +1 every cycle, wrapping.
- **Request completion (push).** On in_hs & tlast, ts is pushed into the FIFO and pkts_in increments.
- **Response completion (pop).** On out_hs & tlast:
  - If outstanding > 0: pop the head, compute lat = ts − head modulo 2^TS_WIDTH (wrap-safe), and increment pkts_out.
  - If outstanding == 0: set underflow_o, increment pkts_out, and leave latency state unchanged.
- **Simultaneous push and pop.**
  - Both take effect and outstanding is unchanged.
  - If outstanding was 0, the pop is an underflow and the push is still stored.
- **Drain.**
  - drain_i sets drain_pend.
  - drain_pend clears in the first cycle in which outstanding == 0 and in_mid == 0, including the cycle after it was set if those conditions already hold.
  - drain_i and the clear condition in the same cycle: set wins.
- **Statistics.**
  - Each valid pop updates lat_min = min(lat_min, lat), lat_max = max(lat_max, lat) and lat_sum += lat. lat_sum wraps.
  - stat_clr_i zeroes pkts_in, pkts_out, lat_max, lat_sum and underflow, and sets lat_min to all-ones.
  - stat_clr_i does not touch the FIFO, outstanding, drain_pend or ts.
  - If stat_clr_i coincides with a push or pop, the clear wins for statistics; the FIFO still pushes and pops.
  - Counters wrap at 2^CNT_WIDTH.

## Timing
- **Reset values.** outstanding_o, lat_valid_o, lat_value_o, pkts_*, lat_max_o, lat_sum_o, underflow_o, in_mid, drain_pend and ts are 0. lat_min_o is all-ones. FIFO pointers are 0.
- **Pass-through latency.** 0 cycles, combinational. gate is driven from registers only.
- **Latency report.** lat_valid_o and lat_value_o are registered and appear 1 cycle after the pop handshake. Statistics outputs update in that same cycle.
- **Latency value.** Measured from the cycle of the request's last-beat handshake to the cycle of the response's last-beat handshake. Minimum reportable latency is 1.
- **Count outputs.** outstanding_o and pkts_*_o are registered and update 1 cycle after their handshake.
- **Reset mid-packet.** All state returns to its reset value. Pass-through wires follow their inputs; from_net_tready follows to_kvs_tready once reset is released.

## Test plan
- **Single request.** A 3-beat request, then a 2-beat response whose last beat arrives 20 cycles after the request's last beat. Expect lat_value_o=20 with lat_valid_o for one cycle, pkts_in=pkts_out=1, lat_min=lat_max=lat_sum=20.
- **Outstanding limit.** MAX_OUTSTANDING=4, 6 back-to-back single-beat requests, to_kvs_tready=1, no responses. Expect from_net_tready=0 after the 4th and outstanding_o=4. One response reopens the gate exactly one packet's worth.
- **Drain.** Pulse drain_i while a 4-beat request is on beat 2. Expect that packet to complete and the next to be stalled until outstanding_o=0, after which from_net_tready follows to_kvs_tready.
- **Underflow.** A response with outstanding=0. Expect underflow_o=1 sticky, pkts_out=1, no lat_valid_o and lat_min unchanged. A following stat_clr_i clears underflow_o.
- **Timestamp wrap.** TS_WIDTH=8, request last beat at ts=250, response last beat at ts=4. Expect lat_value_o=10.
- **Simultaneous push/pop.** With outstanding=2, a request last beat and a response last beat in the same cycle. Expect outstanding_o=2 and the reported latency measured against the oldest timestamp.
